wave_seq_ctrl: RTL and testbench
================================

WAVE_SEQ_CTRL -- requirements
Module: wave_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of stored waveform profiles (power of two, 2..16).
REQ-002 SHALL have parameter DWELL_W, default 16, the width of the per-profile dwell counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cfg_we  in  1  profile-table write strobe.
REQ-006 cfg_addr  in  log2(DEPTH)  profile index to write.
REQ-007 cfg_amp  in  8 signed  profile amplitude.
REQ-008 cfg_freq  in  8  profile phase increment.
REQ-009 cfg_wave  in  2  profile waveform select (00 sine, 01 rect, 10 saw, 11 tri).
REQ-010 cfg_duty  in  8  profile rectangle duty cycle.
REQ-011 cfg_dwell  in  DWELL_W  profile hold time in clocks.
REQ-012 start  in  1  begin a sequence.
REQ-013 stop  in  1  abort the sequence.
REQ-014 loop_en  in  1  restart at profile 0 after the last profile.
REQ-015 last_idx  in  log2(DEPTH)  index of the final profile.
REQ-016 amp  out  8 signed  amplitude to the generator.
REQ-017 freq  out  8  frequency word to the generator.
REQ-018 wave_sel  out  2  waveform select to the generator.
REQ-019 duty_cycle  out  8  duty cycle to the generator.
REQ-020 busy  out  1  high in LOAD or RUN.
REQ-021 step_idx  out  log2(DEPTH)  index of the active profile.
REQ-022 step_pulse  out  1  one-cycle pulse when a new profile is applied.
REQ-023 done  out  1  one-cycle pulse at the end of a non-looping sequence.

Function
REQ-024 SHALL write all cfg_* fields into table[cfg_addr] on the clock where cfg_we=1, in any state; a write to the active entry takes effect only at its next LOAD.
REQ-025 SHALL use FSM states IDLE, LOAD and RUN.
REQ-026 IDLE, start=1, stop=0: SHALL capture last_idx, set the index to 0, and go to LOAD; start is ignored in LOAD and RUN.
REQ-027 LOAD (one cycle): SHALL register table[idx] onto amp/freq/wave_sel/duty_cycle, set step_idx=idx, load the dwell counter with max(dwell,1), pulse step_pulse on the same edge, then go to RUN.
REQ-028 RUN: SHALL decrement the dwell counter each clock; on the clock it reaches 0, one of the following SHALL apply.
  - idx<captured last_idx: idx+1, go to LOAD.
  - idx=captured last_idx and loop_en=1 (sampled at that clock): idx=0, go to LOAD.
  - otherwise: go to IDLE, pulse done.
REQ-029 Each profile SHALL therefore be held max(dwell,1)+1 clocks, measured step_pulse to step_pulse.
REQ-030 stop=1 SHALL force IDLE on the next edge from any state, with amp=0 and done not pulsed; stop SHALL win over a simultaneous start or step end.
REQ-031 In IDLE, amp SHALL be 0 (muted); freq, wave_sel and duty_cycle SHALL hold their last values.
REQ-032 A captured last_idx of 0 SHALL play profile 0 only.

Reset
REQ-033 rst SHALL immediately clear the FSM to IDLE and clear all outputs, the index, the dwell counter and every table entry to 0, including mid-sequence.

Configuration
REQ-034 Macro WSEQ_RAMP_EN defined: in RUN, amp SHALL move toward the profile amplitude by ±1 per clock from its previous value and stop at the target; LOAD SHALL latch the target only; stop and reset still zero amp immediately.
REQ-035 Macro WSEQ_RAMP_EN undefined: amp SHALL step to the profile value at LOAD, and no ramp logic SHALL exist.

Verification
REQ-036 Write profile 0 as (amp 50, freq 4, wave 00, dwell 3) and profile 1 as (amp -20, freq 9, wave 01, duty 64, dwell 5); start with last_idx=1, loop_en=0 -> step_pulse 4 clocks apart, outputs match each profile, done pulses once, amp=0 after.
REQ-037 Same table with loop_en=1 -> step_idx cycles 0,1,0,1; busy stays high; done is never asserted.
REQ-038 Assert stop in the 2nd RUN cycle of profile 1 -> IDLE next edge, amp=0, freq holds 9, no done.
REQ-039 Profile dwell=0 -> profile held 2 clocks; start and stop asserted together in IDLE -> stays IDLE.
REQ-040 Assert rst asynchronously mid-RUN -> outputs are 0 before the next clk edge; the table reads back as all-0 profiles.
REQ-041 With WSEQ_RAMP_EN: amp goes from 0 to target 5 -> reaches 5 after 5 RUN clocks (dwell 10) and then holds.

Source files
------------

// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: steps through a table of waveform profiles and drives the
// generator control words. Each profile is applied in a one-cycle LOAD and
// held in RUN for max(dwell,1) further clocks. The sequence then moves to the
// next profile, wraps to profile 0, or returns to IDLE.
// Optional feature: define WSEQ_RAMP_EN to slew amp toward each profile's
// amplitude by 1 per RUN clock instead of stepping it at LOAD.
// Control protocol: start and stop are level-sampled strobes with no
// handshake. stop has the highest priority. start is only honoured in IDLE.
module wave_seq_ctrl #(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 16,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic signed [7:0]  cfg_amp,
    input  logic [7:0]         cfg_freq,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_duty,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [AW-1:0]      last_idx,
    output logic signed [7:0]  amp,
    output logic [7:0]         freq,
    output logic [1:0]         wave_sel,
    output logic [7:0]         duty_cycle,
    output logic               busy,
    output logic [AW-1:0]      step_idx,
    output logic               step_pulse,
    output logic               done,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Profile table
    logic signed [7:0]  amp_tab_q   [DEPTH];
    logic [7:0]         freq_tab_q  [DEPTH];
    logic [1:0]         wave_tab_q  [DEPTH];
    logic [7:0]         duty_tab_q  [DEPTH];
    logic [DWELL_W-1:0] dwell_tab_q [DEPTH];

    // Sequencer state and registered outputs
    state_t             state_q;
    logic [AW-1:0]      idx_q;
    logic [AW-1:0]      last_q;
    logic [DWELL_W-1:0] dwell_q;
    logic signed [7:0]  amp_q;
    logic [7:0]         freq_q;
    logic [1:0]         wave_q;
    logic [7:0]         duty_q;
    logic [AW-1:0]      step_idx_q;
    logic               step_pulse_q;
    logic               done_q;
`ifdef WSEQ_RAMP_EN
    logic signed [7:0]  target_q;
`endif

    // Dwell value to load for the profile being entered; zero is treated as one
    logic [DWELL_W-1:0] dwell_ld_d;

    // Clamp the stored dwell of the current index to at least one clock
    always_comb begin
        dwell_ld_d = dwell_tab_q[idx_q];
        if (dwell_tab_q[idx_q] == '0) begin
            dwell_ld_d = DWELL_W'(1);
        end
    end

    // Profile table writes, accepted in any state; cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                amp_tab_q[i]   <= '0;
                freq_tab_q[i]  <= '0;
                wave_tab_q[i]  <= '0;
                duty_tab_q[i]  <= '0;
                dwell_tab_q[i] <= '0;
            end
        end else if (cfg_we) begin
            amp_tab_q[cfg_addr]   <= cfg_amp;
            freq_tab_q[cfg_addr]  <= cfg_freq;
            wave_tab_q[cfg_addr]  <= cfg_wave;
            duty_tab_q[cfg_addr]  <= cfg_duty;
            dwell_tab_q[cfg_addr] <= cfg_dwell;
        end
    end

    // Sequencer FSM with registered generator outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            dwell_q      <= '0;
            amp_q        <= '0;
            freq_q       <= '0;
            wave_q       <= '0;
            duty_q       <= '0;
            step_idx_q   <= '0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef WSEQ_RAMP_EN
            target_q     <= '0;
`endif
        end else begin
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef WSEQ_RAMP_EN
            // Slew one LSB per RUN clock toward the latched target
            if (state_q == S_RUN) begin
                if (amp_q < target_q) begin
                    amp_q <= amp_q + 8'sd1;
                end else if (amp_q > target_q) begin
                    amp_q <= amp_q - 8'sd1;
                end
            end
`endif
            if (stop) begin
                // Abort: mute immediately, keep the other control words
                state_q <= S_IDLE;
                amp_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            last_q  <= last_idx;
                            idx_q   <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
`ifdef WSEQ_RAMP_EN
                        target_q     <= amp_tab_q[idx_q];
`else
                        amp_q        <= amp_tab_q[idx_q];
`endif
                        freq_q       <= freq_tab_q[idx_q];
                        wave_q       <= wave_tab_q[idx_q];
                        duty_q       <= duty_tab_q[idx_q];
                        step_idx_q   <= idx_q;
                        dwell_q      <= dwell_ld_d;
                        step_pulse_q <= 1'b1;
                        state_q      <= S_RUN;
                    end
                    S_RUN: begin
                        dwell_q <= dwell_q - DWELL_W'(1);
                        // Counter reaches zero on this edge: decide the next step
                        if (dwell_q <= DWELL_W'(1)) begin
                            dwell_q <= '0;
                            if (idx_q < last_q) begin
                                idx_q   <= idx_q + AW'(1);
                                state_q <= S_LOAD;
                            end else if (loop_en) begin
                                idx_q   <= '0;
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_IDLE;
                                amp_q   <= '0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        amp_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign amp        = amp_q;
    assign freq       = freq_q;
    assign wave_sel   = wave_q;
    assign duty_cycle = duty_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
    assign step_idx   = step_idx_q;
    assign step_pulse = step_pulse_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Bench for wave_seq_ctrl: a table of per-cycle vectors plus hand-written
// sequences for dwell=0, start+stop, asynchronous reset and the amp ramp
// option (WSEQ_RAMP_EN).
module tb_wave_seq_ctrl;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic signed [7:0] cfg_amp;
    logic [7:0]        cfg_freq;
    logic [1:0]        cfg_wave;
    logic [7:0]        cfg_duty;
    logic [15:0]       cfg_dwell;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [2:0]        last_idx;
    logic signed [7:0] amp;
    logic [7:0]        freq;
    logic [1:0]        wave_sel;
    logic [7:0]        duty_cycle;
    logic              busy;
    logic [2:0]        step_idx;
    logic              step_pulse;
    logic              done;
    logic [1:0]        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        s;
        logic        p;
        logic        l;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs[NV];

    wave_seq_ctrl #(.DEPTH(8), .DWELL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_amp    (cfg_amp),
        .cfg_freq   (cfg_freq),
        .cfg_wave   (cfg_wave),
        .cfg_duty   (cfg_duty),
        .cfg_dwell  (cfg_dwell),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .last_idx   (last_idx),
        .amp        (amp),
        .freq       (freq),
        .wave_sel   (wave_sel),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "timeout");
    end

    // Pack {amp, freq, wave, duty, busy, step_idx, step_pulse, done}
    function automatic logic [31:0] pk(input int a, input int f, input int w, input int d,
                                       input bit b, input int i, input bit s, input bit dn);
        return {8'(a), 8'(f), 2'(w), 8'(d), b, 3'(i), s, dn};
    endfunction

    task automatic check(input string name);
        logic [31:0] act;
        logic [31:0] exp;
        act = {amp, freq, wave_sel, duty_cycle, busy, step_idx, step_pulse, done};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected value queued, got %h", name, act);
            return;
        end
        exp = exp_q.pop_front();
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got amp=%0d freq=%0d wave=%0d duty=%0d busy=%0b idx=%0d pulse=%0b done=%0b (%h), expected %h",
                     name, amp, freq, wave_sel, duty_cycle, busy, step_idx, step_pulse, done, act, exp);
        end
    endtask

    // Apply inputs for one clock, queue the expected result, compare after the edge
    task automatic drive(input logic s, input logic p, input logic l,
                         input logic [31:0] exp, input string name);
        start   = s;
        stop    = p;
        loop_en = l;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(name);
    endtask

    // Apply inputs for one clock without checking
    task automatic go(input logic s, input logic p, input logic l);
        start   = s;
        stop    = p;
        loop_en = l;
        @(posedge clk);
        #1;
    endtask

    task automatic write_prof(input int a, input int am, input int f, input int w,
                              input int d, input int dw);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(a);
        cfg_amp   = 8'(am);
        cfg_freq  = 8'(f);
        cfg_wave  = 2'(w);
        cfg_duty  = 8'(d);
        cfg_dwell = 16'(dw);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        logic [31:0] p0_run;
        logic [31:0] p0_ld;
        logic [31:0] p1_run;
        logic [31:0] p1_ld;
        logic [31:0] idle91;

        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_amp = '0; cfg_freq = '0;
        cfg_wave = '0; cfg_duty = '0; cfg_dwell = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_idx = '0;

        #2;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0));
        check("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef WSEQ_RAMP_EN
        // Ramp: amp climbs 0->5 over 5 RUN clocks, then holds until the end
        write_prof(0, 5, 3, 0, 0, 10);
        last_idx = 3'd0;
        drive(1, 0, 0, pk(0, 0, 0, 0, 1, 0, 0, 0), "ramp_start");
        drive(0, 0, 0, pk(0, 3, 0, 0, 1, 0, 1, 0), "ramp_load");
        for (int k = 1; k <= 9; k++) begin
            drive(0, 0, 0, pk((k < 5) ? k : 5, 3, 0, 0, 1, 0, 0, 0), $sformatf("ramp_run%0d", k));
        end
        drive(0, 0, 0, pk(0, 3, 0, 0, 0, 0, 0, 1), "ramp_done");
        drive(0, 0, 0, pk(0, 3, 0, 0, 0, 0, 0, 0), "ramp_idle");
`else
        // Two-profile sequence, then the same table looping, then a stop
        write_prof(0, 50, 4, 0, 0, 3);
        write_prof(1, -20, 9, 1, 64, 5);
        last_idx = 3'd1;

        p0_run = pk(50, 4, 0, 0, 1, 0, 0, 0);
        p0_ld  = pk(50, 4, 0, 0, 1, 0, 1, 0);
        p1_run = pk(-20, 9, 1, 64, 1, 1, 0, 0);
        p1_ld  = pk(-20, 9, 1, 64, 1, 1, 1, 0);
        idle91 = pk(0, 9, 1, 64, 0, 1, 0, 0);

        vecs[0]  = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, p0_ld};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, p0_run};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, p0_run};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, p0_run};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, p1_ld};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, p1_run};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, p1_run};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, p1_run};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, p1_run};
        vecs[10] = '{1'b0, 1'b0, 1'b0, pk(0, 9, 1, 64, 0, 1, 0, 1)};
        vecs[11] = '{1'b0, 1'b0, 1'b0, idle91};
        vecs[12] = '{1'b1, 1'b0, 1'b1, pk(0, 9, 1, 64, 1, 1, 0, 0)};
        vecs[13] = '{1'b0, 1'b0, 1'b1, p0_ld};
        vecs[14] = '{1'b0, 1'b0, 1'b1, p0_run};
        vecs[15] = '{1'b0, 1'b0, 1'b1, p0_run};
        vecs[16] = '{1'b0, 1'b0, 1'b1, p0_run};
        vecs[17] = '{1'b0, 1'b0, 1'b1, p1_ld};
        vecs[18] = '{1'b0, 1'b0, 1'b1, p1_run};
        vecs[19] = '{1'b0, 1'b0, 1'b1, p1_run};
        vecs[20] = '{1'b0, 1'b0, 1'b1, p1_run};
        vecs[21] = '{1'b0, 1'b0, 1'b1, p1_run};
        vecs[22] = '{1'b0, 1'b0, 1'b1, p1_run};
        vecs[23] = '{1'b0, 1'b0, 1'b1, p0_ld};
        vecs[24] = '{1'b0, 1'b0, 1'b1, p0_run};
        vecs[25] = '{1'b0, 1'b0, 1'b1, p0_run};
        vecs[26] = '{1'b0, 1'b0, 1'b1, p0_run};
        vecs[27] = '{1'b0, 1'b0, 1'b1, p1_ld};
        vecs[28] = '{1'b0, 1'b0, 1'b1, p1_run};
        vecs[29] = '{1'b0, 1'b1, 1'b1, idle91};
        vecs[30] = '{1'b0, 1'b0, 1'b0, idle91};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].s, vecs[i].p, vecs[i].l, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // dwell=0 with last_idx=0 and looping: step_pulse every 2 clocks
        write_prof(0, 7, 1, 2, 0, 0);
        last_idx = 3'd0;
        drive(1, 0, 1, pk(0, 9, 1, 64, 1, 1, 0, 0), "dw0_start");
        drive(0, 0, 1, pk(7, 1, 2, 0, 1, 0, 1, 0), "dw0_load1");
        drive(0, 0, 1, pk(7, 1, 2, 0, 1, 0, 0, 0), "dw0_run1");
        drive(0, 0, 1, pk(7, 1, 2, 0, 1, 0, 1, 0), "dw0_load2");
        drive(0, 0, 1, pk(7, 1, 2, 0, 1, 0, 0, 0), "dw0_run2");
        drive(0, 0, 1, pk(7, 1, 2, 0, 1, 0, 1, 0), "dw0_load3");
        drive(0, 1, 1, pk(0, 1, 2, 0, 0, 0, 0, 0), "dw0_stop");

        // last_idx=0 without looping: profile 0 once, then done
        drive(1, 0, 0, pk(0, 1, 2, 0, 1, 0, 0, 0), "one_start");
        drive(0, 0, 0, pk(7, 1, 2, 0, 1, 0, 1, 0), "one_load");
        drive(0, 0, 0, pk(0, 1, 2, 0, 0, 0, 0, 1), "one_done");
        drive(0, 0, 0, pk(0, 1, 2, 0, 0, 0, 0, 0), "one_idle");

        // start and stop together in IDLE: stay idle
        drive(1, 1, 0, pk(0, 1, 2, 0, 0, 0, 0, 0), "start_stop");
        drive(0, 0, 0, pk(0, 1, 2, 0, 0, 0, 0, 0), "start_stop_idle");
`endif

        // Asynchronous reset in the middle of a running sequence
        write_prof(0, 7, 1, 2, 0, 0);
        last_idx = 3'd0;
        go(1, 0, 1);
        go(0, 0, 1);
        go(0, 0, 1);
        #3;
        rst = 1'b1;
        #1;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0));
        check("async_reset");
        #1;
        rst = 1'b0;

        // Table is all zero after reset: zero outputs, dwell treated as 1
        last_idx = 3'd1;
        drive(1, 0, 0, pk(0, 0, 0, 0, 1, 0, 0, 0), "rb_start");
        drive(0, 0, 0, pk(0, 0, 0, 0, 1, 0, 1, 0), "rb_load0");
        drive(0, 0, 0, pk(0, 0, 0, 0, 1, 0, 0, 0), "rb_run0");
        drive(0, 0, 0, pk(0, 0, 0, 0, 1, 1, 1, 0), "rb_load1");
        drive(0, 0, 0, pk(0, 0, 0, 0, 0, 1, 0, 1), "rb_done");

        start = 1'b0;
        stop  = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
